prio_enc_rr: RTL and testbench

//  Parametrised, registered N-to-log2(N) priority encoder. Adds a selectable

---
 rtl/prio_enc_rr.sv | 114 +++++++++++
 tb/tb_prio_enc_rr.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/prio_enc_rr.sv
// Registered N-to-log2(N) priority encoder with fixed-priority and round-robin modes.
// Latency: req sampled on edge k appears on out_* after edge k; one grant per cycle with out_ready high.
// Backpressure: outputs hold frozen while out_valid && !out_ready; requests are not latched meanwhile.
module prio_enc_rr #(
    parameter int N = 8,
    localparam int W = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req,
    input  logic         mode,
    input  logic         out_ready,
    output logic         out_valid,
    output logic [W-1:0] out_idx,
    output logic [N-1:0] out_onehot,
    output logic         out_multi
);

    localparam logic [W-1:0] LAST  = W'(N - 1);
    localparam logic [W:0]   N_EXT = (W + 1)'(N);

    typedef enum logic {IDLE, HOLD} state_t;

    state_t       state;
    logic [W-1:0] ptr;
    // Remembers whether the held grant was won in round-robin mode, so the
    // pointer only advances for rr grants even if mode changed during HOLD.
    logic         held_rr;

    logic           hs;
    logic           any_req;
    logic [W-1:0]   ptr_adv;
    logic [W-1:0]   search_ptr;
    logic [2*N-1:0] rot;
    logic [W-1:0]   rr_off;
    logic [W:0]     rr_sum;
    logic [W-1:0]   rr_idx;
    logic [W-1:0]   win_idx;
    logic           win_multi;

    function automatic logic [W-1:0] lowest_set(input logic [N-1:0] v);
        logic [W-1:0] r;
        r = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (v[i]) r = W'(i);
        end
        return r;
    endfunction

    // Winner selection; the rr search starts from the pointer as it will be
    // after this edge's handshake, so back-to-back grants rotate correctly.
    always_comb begin
        hs         = out_valid && out_ready;
        any_req    = |req;
        ptr_adv    = (out_idx == LAST) ? '0 : out_idx + W'(1);
        search_ptr = (hs && held_rr) ? ptr_adv : ptr;
        // Rotate so the search origin lands on bit 0, then map back modulo N.
        rot        = {req, req} >> search_ptr;
        rr_off     = lowest_set(rot[N-1:0]);
        rr_sum     = {1'b0, search_ptr} + {1'b0, rr_off};
        rr_idx     = (rr_sum >= N_EXT) ? W'(rr_sum - N_EXT) : rr_sum[W-1:0];
        win_idx    = mode ? rr_idx : lowest_set(req);
        // More than one bit set iff clearing the lowest set bit leaves something.
        win_multi  = (req & (req - N'(1))) != '0;
    end

    // Two-state capture/hold FSM with registered outputs and rr pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            ptr        <= '0;
            held_rr    <= 1'b0;
            out_valid  <= 1'b0;
            out_idx    <= '0;
            out_onehot <= '0;
            out_multi  <= 1'b0;
        end else begin
            if (hs && held_rr) begin
                ptr <= ptr_adv;
            end
            case (state)
                IDLE: begin
                    if (any_req) begin
                        state      <= HOLD;
                        held_rr    <= mode;
                        out_valid  <= 1'b1;
                        out_idx    <= win_idx;
                        out_onehot <= N'(1) << win_idx;
                        out_multi  <= win_multi;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        if (any_req) begin
                            held_rr    <= mode;
                            out_idx    <= win_idx;
                            out_onehot <= N'(1) << win_idx;
                            out_multi  <= win_multi;
                        end else begin
                            state      <= IDLE;
                            held_rr    <= 1'b0;
                            out_valid  <= 1'b0;
                            out_idx    <= '0;
                            out_onehot <= '0;
                            out_multi  <= 1'b0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_prio_enc_rr.sv
module tb_prio_enc_rr;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;

    logic [7:0] req8 = '0;
    logic       mode8 = 1'b0;
    logic       rdy8 = 1'b0;
    logic       v8;
    logic [2:0] idx8;
    logic [7:0] oh8;
    logic       mul8;

    logic [4:0] req5 = '0;
    logic       mode5 = 1'b0;
    logic       rdy5 = 1'b0;
    logic       v5;
    logic [2:0] idx5;
    logic [4:0] oh5;
    logic       mul5;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    prio_enc_rr #(.N(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .req(req8), .mode(mode8), .out_ready(rdy8),
        .out_valid(v8), .out_idx(idx8), .out_onehot(oh8), .out_multi(mul8)
    );

    prio_enc_rr #(.N(5)) dut5 (
        .clk(clk), .rst_n(rst_n), .req(req5), .mode(mode5), .out_ready(rdy5),
        .out_valid(v5), .out_idx(idx5), .out_onehot(oh5), .out_multi(mul5)
    );

    // Behavioural model: what the consumer should see, derived from the rules.
    typedef struct {
        int valid;
        int idx;
        int multi;
        int ptr;
        int rr;
    } mdl_t;

    mdl_t m8, m5;

    function automatic mdl_t step(mdl_t s, int n, logic [7:0] rq, logic md, logic rdy);
        mdl_t r;
        int start;
        int cnt;
        r = s;
        if (s.valid != 0 && !rdy) return s;
        start = s.ptr;
        if (s.valid != 0 && s.rr != 0) begin
            r.ptr = (s.idx + 1) % n;
            start = r.ptr;
        end
        cnt = 0;
        for (int i = 0; i < n; i++) if (rq[i]) cnt++;
        if (cnt == 0) begin
            r.valid = 0;
            r.idx = 0;
            r.multi = 0;
            r.rr = 0;
            return r;
        end
        r.valid = 1;
        r.multi = (cnt > 1) ? 1 : 0;
        r.rr = md ? 1 : 0;
        r.idx = -1;
        for (int k = 0; k < n; k++) begin
            int j;
            j = md ? (start + k) % n : k;
            if (r.idx < 0 && rq[j]) r.idx = j;
        end
        return r;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m8 <= '{default: 0};
            m5 <= '{default: 0};
        end else begin
            m8 <= step(m8, 8, req8, mode8, rdy8);
            m5 <= step(m5, 5, {3'b000, req5}, mode5, rdy5);
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Continuous compare against the model, away from the active edge.
    always @(negedge clk) begin
        chk("m8_valid", int'(v8), m8.valid);
        chk("m8_onehot", int'(oh8), (m8.valid != 0) ? (1 << m8.idx) : 0);
        if (m8.valid != 0) begin
            chk("m8_idx", int'(idx8), m8.idx);
            chk("m8_multi", int'(mul8), m8.multi);
        end
        chk("m5_valid", int'(v5), m5.valid);
        chk("m5_onehot", int'(oh5), (m5.valid != 0) ? (1 << m5.idx) : 0);
        if (m5.valid != 0) begin
            chk("m5_idx", int'(idx5), m5.idx);
            chk("m5_multi", int'(mul5), m5.multi);
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    logic [7:0] toggle_tbl [5] = '{8'h01, 8'h80, 8'h00, 8'h3C, 8'hFF};
    int expect5 [4] = '{0, 4, 0, 4};

    initial begin
        // Reset state
        #12;
        chk("rst_valid", int'(v8), 0);
        chk("rst_idx", int'(idx8), 0);
        chk("rst_onehot", int'(oh8), 0);
        rst_n = 1'b1;
        cyc(1);

        // 1: capture then async reset mid-hold
        mode8 = 1'b0; req8 = 8'h04; rdy8 = 1'b0;
        cyc(1);
        chk("t1_valid", int'(v8), 1);
        chk("t1_idx", int'(idx8), 2);
        cyc(2);
        chk("t1_hold_idx", int'(idx8), 2);
        #3 rst_n = 1'b0;
        #1;
        chk("t1_async_valid", int'(v8), 0);
        chk("t1_async_idx", int'(idx8), 0);
        chk("t1_async_onehot", int'(oh8), 0);
        req8 = 8'h00;
        #2 rst_n = 1'b1;
        cyc(1);

        // 2: fixed priority
        mode8 = 1'b0; rdy8 = 1'b1; req8 = 8'b1010_0100;
        cyc(1);
        chk("t2_idx", int'(idx8), 2);
        chk("t2_onehot", int'(oh8), 8'h04);
        chk("t2_multi", int'(mul8), 1);
        req8 = 8'h80;
        cyc(1);
        chk("t2_idx7", int'(idx8), 7);
        chk("t2_multi0", int'(mul8), 0);
        req8 = 8'h00;
        cyc(1);
        chk("t2_idle", int'(v8), 0);

        // 3: round-robin sweep
        mode8 = 1'b1; req8 = 8'hFF; rdy8 = 1'b1;
        cyc(1);
        chk("t3_idx0", int'(idx8), 0);
        for (int k = 1; k <= 8; k++) begin
            cyc(1);
            chk("t3_sweep_idx", int'(idx8), k % 8);
            chk("t3_sweep_valid", int'(v8), 1);
        end

        // 4: backpressure with toggling req and mode, held idx=0
        rdy8 = 1'b0;
        for (int k = 0; k < 5; k++) begin
            req8 = toggle_tbl[k];
            mode8 = k[0];
            cyc(1);
            chk("t4_hold_idx", int'(idx8), 0);
            chk("t4_hold_onehot", int'(oh8), 8'h01);
            chk("t4_hold_multi", int'(mul8), 1);
        end
        rdy8 = 1'b1; mode8 = 1'b1; req8 = 8'b0000_0101;
        cyc(1);
        chk("t4_rr_after", int'(idx8), 2);
        cyc(1);
        chk("t4_rr_wrap", int'(idx8), 0);
        req8 = 8'h00;
        cyc(1);

        // 5: non-power-of-2 wrap on N=5
        mode5 = 1'b1; rdy5 = 1'b1; req5 = 5'b10001;
        for (int k = 0; k < 4; k++) begin
            cyc(1);
            chk("t5_idx", int'(idx5), expect5[k]);
            chk("t5_idx_le4", int'(idx5 <= 3'd4), 1);
        end
        req5 = 5'b00000;
        cyc(1);
        chk("t5_idle", int'(v5), 0);

        // 6: idle with no requests, then a single-cycle pulse
        req8 = 8'h00;
        for (int k = 0; k < 10; k++) begin
            cyc(1);
            chk("t6_idle", int'(v8), 0);
        end
        req8 = 8'h10;
        cyc(1);
        req8 = 8'h00;
        chk("t6_pulse_valid", int'(v8), 1);
        chk("t6_pulse_idx", int'(idx8), 4);
        cyc(1);
        chk("t6_back_idle", int'(v8), 0);
        cyc(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
